alu_vector_checker: RTL and testbench

//  Synthesizable self-checking driver for the combinational alu (a, b, f -> y, cout, overflow, zero).

---
 rtl/alu_chk_pkg.sv | 35 +++
 rtl/alu_vector_checker_if.sv | 18 +
 rtl/alu_vec_mem.sv | 22 ++
 rtl/alu_vector_checker.sv | 129 ++++++++++++
 tb/tb_alu_vector_checker.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_chk_pkg.sv
// Shared types for the alu vector checker: alu function codes, vector layout, FSM state codes.
package alu_chk_pkg;

  localparam int ALU_N = 32;
  localparam int ALU_M = 3;
  localparam int VEC_W = ALU_M + 3*ALU_N + 3;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_fn_e;

  // Field order matches the load_data bit layout, MSB first.
  typedef struct packed {
    logic [ALU_M-1:0] f;
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic [ALU_N-1:0] y;
    logic             cout;
    logic             ovf;
    logic             zero;
  } alu_vec_t;

  typedef logic [2:0] chk_state_t;
  localparam chk_state_t S_IDLE  = 3'd0;
  localparam chk_state_t S_FETCH = 3'd1;
  localparam chk_state_t S_APPLY = 3'd2;
  localparam chk_state_t S_WAIT  = 3'd3;
  localparam chk_state_t S_CHECK = 3'd4;
  localparam chk_state_t S_DONE  = 3'd5;

endpackage

// File: rtl/alu_vector_checker_if.sv
// Operand/result bus between the vector checker (master) and the alu under test (slave).
interface alu_vector_checker_if #(
  parameter int N = 32,
  parameter int M = 3
);
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [M-1:0] alu_f;
  logic [N-1:0] alu_y;
  logic         alu_cout;
  logic         alu_overflow;
  logic         alu_zero;

  modport master (output alu_a, alu_b, alu_f,
                  input  alu_y, alu_cout, alu_overflow, alu_zero);
  modport slave  (input  alu_a, alu_b, alu_f,
                  output alu_y, alu_cout, alu_overflow, alu_zero);
endinterface

// File: rtl/alu_vec_mem.sv
// Single-port synchronous vector table; one address shared by the load port and the FSM.
module alu_vec_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 102,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/alu_vector_checker.sv
// BIST driver: replays stored vectors through the alu and counts result mismatches.
// Define ALU_CHK_STOP_ON_ERR_EN to end the run at the first mismatching vector.
module alu_vector_checker
  import alu_chk_pkg::*;
#(
  parameter int N      = ALU_N,
  parameter int M      = ALU_M,
  parameter int DEPTH  = 64,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int VW    = M + 3*N + 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_we,
  input  logic [AW-1:0]         load_addr,
  input  logic [VW-1:0]         load_data,
  input  logic                  start,
  input  logic [AW:0]           num_vec,
  alu_vector_checker_if.master  alu,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [AW-1:0]         first_err_idx
);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
`ifdef ALU_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  chk_state_t       state_q, state_d;
  logic [AW-1:0]    idx_q;
  logic [AW:0]      num_q, num_eff;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     a_q, b_q;
  logic [M-1:0]     f_q;
  logic [N+2:0]     exp_q;
  logic             done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic [AW-1:0]    fei_q;
  logic [VW-1:0]    rdata;
  logic             idle, mismatch, last;

  assign idle     = (state_q == S_IDLE);
  assign num_eff  = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
  assign mismatch = {alu.alu_y, alu.alu_cout, alu.alu_overflow, alu.alu_zero} != exp_q;
  assign last     = ((AW+1)'(idx_q) + 1'b1) == num_q;

  // The FSM owns the table address for the whole run, so loads are only accepted when idle.
  alu_vec_mem #(.DEPTH(DEPTH), .W(VW), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (load_we && idle),
    .addr_i  (idle ? load_addr : idx_q),
    .wdata_i (load_data),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_vec == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_APPLY;
      S_APPLY: state_d = (SETTLE > 1) ? S_WAIT : S_CHECK;
      S_WAIT:  if (cnt_q == CNT_W'(SETTLE-2)) state_d = S_CHECK;
      S_CHECK: state_d = ((mismatch && STOP_ON_ERR) || last) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fei_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: if (start) begin
          idx_q  <= '0;
          num_q  <= num_eff;
          err_q  <= '0;
          fei_q  <= '0;
          pass_q <= 1'b0;
        end
        S_APPLY: begin
          f_q   <= rdata[VW-1 -: M];
          a_q   <= rdata[3*N+2 -: N];
          b_q   <= rdata[2*N+2 -: N];
          exp_q <= rdata[N+2:0];
          cnt_q <= '0;
        end
        S_WAIT:  cnt_q <= cnt_q + 1'b1;
        S_CHECK: begin
          if (mismatch) begin
            if (err_q == '0) fei_q <= idx_q;
            if (err_q != '1) err_q <= err_q + 1'b1;
          end
          idx_q <= idx_q + 1'b1;
        end
        S_DONE:  pass_q <= (err_q == '0);
        default: ;
      endcase
    end
  end

  assign alu.alu_a     = a_q;
  assign alu.alu_b     = b_q;
  assign alu.alu_f     = f_q;
  assign busy          = !idle;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = fei_q;
endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker with a behavioural alu on the bus and a table-level reference model.
module tb_alu_vector_checker;
  import alu_chk_pkg::*;

  localparam int N = 32, M = 3, DEPTH = 64, AW = 6, SETTLE = 1, ERR_W = 16;
  localparam int VW = VEC_W;
`ifdef ALU_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, load_we, start, busy, done, pass;
  logic [AW-1:0] load_addr, first_err_idx;
  logic [VW-1:0] load_data;
  logic [AW:0] num_vec;
  logic [ERR_W-1:0] err_count;

  int checks = 0, failures = 0;
  alu_vec_t tbl [DEPTH];

  always #5 clk = ~clk;

  alu_vector_checker_if #(.N(N), .M(M)) alu_if ();

  alu_vector_checker #(.N(N), .M(M), .DEPTH(DEPTH), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .num_vec(num_vec), .alu(alu_if.master),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  // Returns {y, cout, overflow, zero}; SUB reports borrow on cout.
  function automatic logic [N+2:0] alu_ref(input logic [M-1:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] y; logic c, o;
    c = 1'b0; o = 1'b0;
    case (f)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: begin {c, y} = {1'b0, a} + {1'b0, b}; o = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]); end
      3'b110: begin y = a - b; c = a < b; o = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]); end
      3'b111: y = ($signed(a) < $signed(b)) ? 1 : 0;
      default: y = '0;
    endcase
    return {y, c, o, (y == '0)};
  endfunction

  always_comb
    {alu_if.alu_y, alu_if.alu_cout, alu_if.alu_overflow, alu_if.alu_zero} =
      alu_ref(alu_if.alu_f, alu_if.alu_a, alu_if.alu_b);

  function automatic alu_vec_t mkvec(input logic [M-1:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    alu_vec_t v; logic [N+2:0] r;
    r = alu_ref(f, a, b);
    v.f = f; v.a = a; v.b = b; {v.y, v.cout, v.ovf, v.zero} = r;
    return v;
  endfunction

  // Run-level prediction from the table contents alone.
  function automatic void predict(input int nraw, output int errs, output int fei, output int applied);
    int n;
    n = (nraw > DEPTH) ? DEPTH : nraw;
    errs = 0; fei = 0; applied = 0;
    for (int i = 0; i < n; i++) begin
      applied++;
      if ({tbl[i].y, tbl[i].cout, tbl[i].ovf, tbl[i].zero} !== alu_ref(tbl[i].f, tbl[i].a, tbl[i].b)) begin
        if (errs == 0) fei = i;
        errs++;
        if (STOP) break;
      end
    end
  endfunction

  task automatic load(input int idx, input alu_vec_t v);
    @(negedge clk);
    load_we = 1'b1; load_addr = AW'(idx); load_data = v;
    tbl[idx] = v;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic run(input int nraw, output int cyc);
    @(negedge clk);
    num_vec = (AW+1)'(nraw); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin @(posedge clk); cyc++; #1; end while (!done && cyc < 2000);
  endtask

  task automatic load_basic();
    load(0, mkvec(3'b010, 32'd1, 32'd2));
    load(1, mkvec(3'b110, 32'd5, 32'd5));
    load(2, mkvec(3'b000, 32'hF0, 32'h0F));
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b want=0", pass); end
    checks++; if (err_count !== '0 || first_err_idx !== '0) begin failures++;
      $display("FAIL reset_err got=%0d/%0d want=0/0", err_count, first_err_idx); end
    checks++; if ({alu_if.alu_a, alu_if.alu_b, alu_if.alu_f} !== '0) begin failures++;
      $display("FAIL reset_alu got=%h/%h/%h want=0", alu_if.alu_a, alu_if.alu_b, alu_if.alu_f); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic_pass();
    int cyc;
    load_basic();
    run(3, cyc);
    checks++; if (cyc !== 10) begin failures++; $display("FAIL basic_latency got=%0d want=10", cyc); end
    checks++; if (pass !== 1'b1 || err_count !== '0) begin failures++;
      $display("FAIL basic_result got pass=%b err=%0d want pass=1 err=0", pass, err_count); end
    checks++; if (alu_if.alu_a !== 32'hF0 || alu_if.alu_b !== 32'h0F || alu_if.alu_f !== 3'b000) begin failures++;
      $display("FAIL basic_hold got=%h/%h/%h want=f0/0f/0", alu_if.alu_a, alu_if.alu_b, alu_if.alu_f); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || pass !== 1'b1) begin failures++;
      $display("FAIL basic_done_pulse got done=%b pass=%b want done=0 pass=1", done, pass); end
  endtask

  task automatic test_one_error();
    int cyc, errs, fei, app;
    alu_vec_t v;
    v = tbl[1]; v.y = 32'd1; load(1, v);
    predict(3, errs, fei, app);
    run(3, cyc);
    checks++; if (cyc !== app*(2+SETTLE)+1) begin failures++;
      $display("FAIL err_latency got=%0d want=%0d", cyc, app*(2+SETTLE)+1); end
    checks++; if (err_count !== ERR_W'(errs) || first_err_idx !== AW'(fei) || pass !== 1'b0) begin failures++;
      $display("FAIL err_result got err=%0d idx=%0d pass=%b want err=%0d idx=%0d pass=0",
               err_count, first_err_idx, pass, errs, fei); end
    checks++; if (alu_if.alu_a !== tbl[app-1].a) begin failures++;
      $display("FAIL err_last_applied got=%h want=%h", alu_if.alu_a, tbl[app-1].a); end
    load(1, mkvec(3'b110, 32'd5, 32'd5));
  endtask

  task automatic test_zero_vec();
    int cyc;
    logic [N-1:0] a0;
    a0 = alu_if.alu_a;
    run(0, cyc);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL zero_latency got=%0d want=1", cyc); end
    checks++; if (pass !== 1'b1 || err_count !== '0) begin failures++;
      $display("FAIL zero_result got pass=%b err=%0d want pass=1 err=0", pass, err_count); end
    checks++; if (alu_if.alu_a !== a0) begin failures++; $display("FAIL zero_hold got=%h want=%h", alu_if.alu_a, a0); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, seen;
    alu_vec_t v;
    v = tbl[0]; v.zero = ~v.zero; load(0, v);
    @(negedge clk); num_vec = 7'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || err_count !== '0 || done !== 1'b0) begin failures++;
      $display("FAIL midreset_state got busy=%b err=%0d done=%b want 0/0/0", busy, err_count, done); end
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d pulses want=0", seen); end
    load(0, mkvec(3'b010, 32'd1, 32'd2));
    run(3, cyc);
    checks++; if (cyc !== 10 || pass !== 1'b1 || err_count !== '0) begin failures++;
      $display("FAIL midreset_rerun got cyc=%0d pass=%b err=%0d want 10/1/0", cyc, pass, err_count); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    alu_vec_t bad;
    bad = tbl[0]; bad.y = ~bad.y;
    @(negedge clk); num_vec = 7'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; load_we = 1'b1; load_addr = '0; load_data = bad;
    cyc = 3;
    @(posedge clk); cyc++; #1 start = 1'b0; load_we = 1'b0;
    while (!done && cyc < 2000) begin @(posedge clk); cyc++; #1; end
    checks++; if (cyc !== 10 || pass !== 1'b1 || err_count !== '0) begin failures++;
      $display("FAIL busy_run got cyc=%0d pass=%b err=%0d want 10/1/0", cyc, pass, err_count); end
    run(3, cyc);
    checks++; if (pass !== 1'b1 || err_count !== '0) begin failures++;
      $display("FAIL busy_table got pass=%b err=%0d want 1/0", pass, err_count); end
  endtask

  task automatic test_stop_on_err();
    int cyc, errs, fei, app;
    alu_vec_t v;
    for (int i = 0; i < 5; i++) load(i, mkvec(3'b010, $urandom, $urandom));
    v = tbl[2]; v.cout = ~v.cout; load(2, v);
    predict(5, errs, fei, app);
    run(5, cyc);
    checks++; if (cyc !== app*(2+SETTLE)+1) begin failures++;
      $display("FAIL stop_latency got=%0d want=%0d", cyc, app*(2+SETTLE)+1); end
    checks++; if (err_count !== ERR_W'(errs) || first_err_idx !== 2) begin failures++;
      $display("FAIL stop_result got err=%0d idx=%0d want err=%0d idx=2", err_count, first_err_idx, errs); end
    checks++; if (alu_if.alu_a !== tbl[app-1].a || alu_if.alu_b !== tbl[app-1].b) begin failures++;
      $display("FAIL stop_hold got=%h/%h want=%h/%h", alu_if.alu_a, alu_if.alu_b, tbl[app-1].a, tbl[app-1].b); end
  endtask

  task automatic test_random();
    int cyc, errs, fei, app, nraw, n;
    logic [M-1:0] fns [5];
    alu_vec_t v;
    fns = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    for (int it = 0; it < 8; it++) begin
      nraw = (it == 3) ? 64 + $urandom_range(1, 63) : $urandom_range(1, 20);
      n = (nraw > DEPTH) ? DEPTH : nraw;
      for (int i = 0; i < n; i++) begin
        v = mkvec(fns[$urandom_range(0, 4)],
                  ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
        if ($urandom_range(0, 5) == 0) v[$urandom_range(0, N+2)] ^= 1'b1;
        load(i, v);
      end
      predict(nraw, errs, fei, app);
      run(nraw, cyc);
      checks++; if (cyc !== app*(2+SETTLE)+1) begin failures++;
        $display("FAIL rand%0d_latency got=%0d want=%0d", it, cyc, app*(2+SETTLE)+1); end
      checks++; if (err_count !== ERR_W'(errs) || pass !== (errs == 0)) begin failures++;
        $display("FAIL rand%0d_errs got err=%0d pass=%b want err=%0d", it, err_count, pass, errs); end
      checks++; if (errs != 0 && first_err_idx !== AW'(fei)) begin failures++;
        $display("FAIL rand%0d_idx got=%0d want=%0d", it, first_err_idx, fei); end
      checks++; if ({alu_if.alu_f, alu_if.alu_a, alu_if.alu_b} !== {tbl[app-1].f, tbl[app-1].a, tbl[app-1].b}) begin
        failures++; $display("FAIL rand%0d_hold got a=%h want a=%h", it, alu_if.alu_a, tbl[app-1].a); end
    end
  endtask

  initial begin
    reset_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; num_vec = '0;
    test_reset();
    test_basic_pass();
    test_one_error();
    test_zero_vec();
    test_reset_mid_run();
    test_busy_ignore();
    test_stop_on_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
